mbscore_wb_stage: RTL and testbench

Registered, parametrised write-back stage for the MBScore core. It accepts one retiring operation per handshake from the execute stage, then does one of three things: writes the ALU result to the register file, stores it to data memory, or loads from memory and writes the sign- or zero-extended value back. Memory accesses use a request/acknowledge handshake guarded by a timeout counter. The stage sits between execute and the register file / data-memory port.

---
 rtl/mbscore_wb_stage.sv | 171 +++++++++++++++++
 tb/tb_mbscore_wb_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mbscore_wb_stage.sv
// rtl/mbscore_wb_stage.sv - MBScore write-back stage: register write, store, or extended load.
// Memory accesses hold mem_* stable until mem_ack or the ACK_TIMEOUT counter expires.
module mbscore_wb_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int ACK_TIMEOUT    = 255
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [1:0]                in_sel,
   input  logic [REG_ADDR_WIDTH-1:0] in_rd,
   input  logic [DATA_WIDTH-1:0]     in_alu,
   input  logic [DATA_WIDTH-1:0]     in_addr,
   input  logic [1:0]                in_size,
   input  logic                      in_signed,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [DATA_WIDTH-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   output logic [1:0]                mem_size,
   input  logic                      mem_ack,
   input  logic [DATA_WIDTH-1:0]     mem_rdata,
   output logic                      rf_we,
   output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0]     rf_wdata,
   output logic                      err
);

   typedef enum logic {S_IDLE, S_MEM_WAIT} state_t;

   localparam logic [1:0]  SEL_ALU_REG = 2'd1;
   localparam logic [1:0]  SEL_ALU_MEM = 2'd2;
   localparam logic [1:0]  SEL_MEM_REG = 2'd3;
   localparam bit          TO_EN       = (ACK_TIMEOUT != 0);
   localparam logic [15:0] TO_LAST     = 16'(ACK_TIMEOUT - 1);

   state_t                    state_q, state_d;
   logic [15:0]               cnt_q, cnt_d;
   logic                      mem_req_q, mem_req_d;
   logic                      mem_we_q, mem_we_d;
   logic [DATA_WIDTH-1:0]     mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
   logic [1:0]                mem_size_q, mem_size_d;
   logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
   logic                      sgn_q, sgn_d;
   logic                      rf_we_q, rf_we_d;
   logic [REG_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_WIDTH-1:0]     rf_wdata_q, rf_wdata_d;
   logic                      err_q, err_d;

   function automatic logic [DATA_WIDTH-1:0] extend_load(
      input logic [DATA_WIDTH-1:0] d,
      input logic [1:0]            sz,
      input logic                  sgn
   );
      logic [DATA_WIDTH-1:0] r;
      r = d;
      if (sz == 2'd0) begin
         for (int i = 8; i < DATA_WIDTH; i++) r[i] = sgn & d[7];
      end else if (sz == 2'd1) begin
         for (int i = 16; i < DATA_WIDTH; i++) r[i] = sgn & d[15];
      end
      return r;
   endfunction

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_size_d  = mem_size_q;
      rd_d        = rd_q;
      sgn_d       = sgn_q;
      rf_we_d     = 1'b0;
      rf_waddr_d  = rf_waddr_q;
      rf_wdata_d  = rf_wdata_q;
      err_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (in_sel == SEL_ALU_REG) begin
                  if (in_rd != '0) begin
                     rf_we_d    = 1'b1;
                     rf_waddr_d = in_rd;
                     rf_wdata_d = in_alu;
                  end
               end else if (in_sel == SEL_ALU_MEM || in_sel == SEL_MEM_REG) begin
                  state_d     = S_MEM_WAIT;
                  cnt_d       = '0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = (in_sel == SEL_ALU_MEM);
                  mem_addr_d  = in_addr;
                  mem_wdata_d = in_alu;
                  mem_size_d  = in_size;
                  rd_d        = in_rd;
                  sgn_d       = in_signed;
               end
            end
         end
         S_MEM_WAIT: begin
            // An ack in the final allowed cycle takes priority over the timeout.
            if (mem_ack) begin
               state_d   = S_IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (!mem_we_q && rd_q != '0) begin
                  rf_we_d    = 1'b1;
                  rf_waddr_d = rd_q;
                  rf_wdata_d = extend_load(mem_rdata, mem_size_q, sgn_q);
               end
            end else if (TO_EN && cnt_q == TO_LAST) begin
               state_d   = S_IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               err_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_size_q  <= '0;
         rd_q        <= '0;
         sgn_q       <= 1'b0;
         rf_we_q     <= 1'b0;
         rf_waddr_q  <= '0;
         rf_wdata_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_size_q  <= mem_size_d;
         rd_q        <= rd_d;
         sgn_q       <= sgn_d;
         rf_we_q     <= rf_we_d;
         rf_waddr_q  <= rf_waddr_d;
         rf_wdata_q  <= rf_wdata_d;
         err_q       <= err_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_size  = mem_size_q;
   assign rf_we     = rf_we_q;
   assign rf_waddr  = rf_waddr_q;
   assign rf_wdata  = rf_wdata_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mbscore_wb_stage.sv
// tb/tb_mbscore_wb_stage.sv - scoreboard bench for mbscore_wb_stage with random and directed operations.
module tb_mbscore_wb_stage;

   localparam int TO = 6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_sel;
   logic [4:0]  in_rd;
   logic [31:0] in_alu;
   logic [31:0] in_addr;
   logic [1:0]  in_size;
   logic        in_signed;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  mem_size;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        err;

   mbscore_wb_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .ACK_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_sel(in_sel), .in_rd(in_rd), .in_alu(in_alu), .in_addr(in_addr),
      .in_size(in_size), .in_signed(in_signed), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      int          cyc;
   } rf_exp_t;

   rf_exp_t rf_q[$];
   int      err_q[$];
   rf_exp_t mon_e;
   int      checks = 0;
   int      errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Load extension expressed as field value, reinterpreted as signed when asked.
   function automatic logic [31:0] ref_extend(input logic [31:0] d, input logic [1:0] sz, input logic sgn);
      longint v;
      if (sz == 2'd0) begin
         v = longint'(d) % 256;
         if (sgn && v >= 128) v = v - 256;
      end else if (sz == 2'd1) begin
         v = longint'(d) % 65536;
         if (sgn && v >= 32768) v = v - 65536;
      end else begin
         v = longint'(d);
      end
      return 32'(v);
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (rf_q.size() > 0 && rf_q[0].cyc <= cyc) begin
            mon_e = rf_q.pop_front();
            chk("rf_we", rf_we, 1);
            chk("rf_waddr", rf_waddr, mon_e.rd);
            chk("rf_wdata", rf_wdata, mon_e.data);
         end else begin
            chk("rf_we_quiet", rf_we, 0);
         end
         if (err_q.size() > 0 && err_q[0] <= cyc) begin
            void'(err_q.pop_front());
            chk("err_pulse", err, 1);
         end else begin
            chk("err_quiet", err, 0);
         end
      end
   end

   // Called at a negedge; returns at the negedge where the next operation may be driven.
   task automatic do_op(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                        input int ack_delay, input logic [31:0] rdata);
      logic store;
      in_valid = 1'b1; in_sel = sel; in_rd = rd; in_alu = alu;
      in_addr = addr; in_size = size; in_signed = sgn;
      chk("in_ready_issue", in_ready, 1);
      if (sel == 2'd1 && rd != 5'd0) rf_q.push_back('{rd, alu, cyc + 1});
      @(negedge clk);
      in_valid = 1'b0;
      in_sel = 2'($urandom); in_alu = $urandom; in_addr = $urandom;
      if (sel == 2'd2 || sel == 2'd3) begin
         store = (sel == 2'd2);
         chk("in_ready_busy", in_ready, 0);
         for (int w = 0; w < TO; w++) begin
            chk("mem_req_held", mem_req, 1);
            chk("mem_we", mem_we, store);
            chk("mem_addr", mem_addr, addr);
            chk("mem_wdata", mem_wdata, alu);
            chk("mem_size", mem_size, size);
            if (w == ack_delay) begin
               mem_ack = 1'b1;
               mem_rdata = rdata;
               if (!store && rd != 5'd0) rf_q.push_back('{rd, ref_extend(rdata, size, sgn), cyc + 1});
               @(negedge clk);
               mem_ack = 1'b0;
               mem_rdata = $urandom;
               break;
            end
            if (w == TO - 1) begin
               err_q.push_back(cyc + 1);
               @(negedge clk);
               break;
            end
            @(negedge clk);
         end
         chk("mem_req_done", mem_req, 0);
         chk("mem_we_done", mem_we, 0);
         chk("in_ready_done", in_ready, 1);
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_size", mem_size, 0);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_waddr", rf_waddr, 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_err", err, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int dly;
      rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_rd = 5'd0; in_alu = '0;
      in_addr = '0; in_size = 2'd0; in_signed = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      chk_reset_vals();
      rst_n = 1'b1;
      @(negedge clk);

      repeat (3) do_op(2'd1, 5'd3, 32'h12345678, 32'h0, 2'd2, 1'b0, 0, 32'h0);
      do_op(2'd2, 5'd9, 32'hDEADBEEF, 32'h100, 2'd2, 1'b0, 4, 32'h0);
      do_op(2'd3, 5'd7, 32'h0, 32'h200, 2'd0, 1'b1, 2, 32'h000000F0);
      do_op(2'd3, 5'd7, 32'h0, 32'h204, 2'd1, 1'b0, 1, 32'h0000F0F0);
      do_op(2'd3, 5'd8, 32'h0, 32'h208, 2'd2, 1'b1, -1, 32'h0);
      do_op(2'd3, 5'd8, 32'h0, 32'h20C, 2'd1, 1'b1, TO - 1, 32'h1234_8001);
      do_op(2'd1, 5'd0, 32'hCAFEF00D, 32'h0, 2'd2, 1'b0, 0, 32'h0);
      do_op(2'd3, 5'd0, 32'h0, 32'h210, 2'd2, 1'b0, 0, 32'h55AA55AA);
      do_op(2'd0, 5'd4, 32'hFFFF0000, 32'h0, 2'd0, 1'b0, 0, 32'h0);
      do_op(2'd3, 5'd31, 32'h0, 32'h214, 2'd3, 1'b1, 0, 32'h8000_0001);

      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("stray_ack_req", mem_req, 0);
      chk("stray_ack_ready", in_ready, 1);

      in_valid = 1'b1; in_sel = 2'd3; in_rd = 5'd5; in_addr = 32'h300; in_size = 2'd2;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_reset_req", mem_req, 1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;
      mem_ack = 1'b1;
      mem_rdata = 32'h7777_7777;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("post_reset_req", mem_req, 0);
      chk("post_reset_ready", in_ready, 1);
      repeat (2) @(negedge clk);

      for (int n = 0; n < 80; n++) begin
         dly = int'($urandom_range(0, TO));
         if (dly == TO) dly = -1;
         do_op(2'($urandom), 5'($urandom), $urandom, $urandom, 2'($urandom), 1'($urandom),
               dly, $urandom);
      end

      repeat (3) @(negedge clk);
      chk("rf_q_drained", rf_q.size(), 0);
      chk("err_q_drained", err_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
